skid_fifo: RTL and testbench
============================

# skid_fifo

Parametrised successor to the two-entry skid buffer: a DEPTH-entry valid/ready elastic FIFO that keeps full throughput while breaking every combinational path between the upstream and downstream handshakes. It sits between pipeline stages where backpressure must be registered, and it reports occupancy and almost-full status for flow control upstream. DATA_WIDTH and DEPTH are free; the old two-entry behaviour is the DEPTH=2 case.

## Interface
- DATA_WIDTH, 8, payload width in bits
- DEPTH, 4, storage entries; power of two, ≥2
- AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ this value; 1..DEPTH
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  upstream data valid
- data_in  in  DATA_WIDTH  upstream payload
- ready_out  out  1  FIFO can accept (upstream ready)
- valid_out  out  1  head entry valid
- data_out  out  DATA_WIDTH  head payload
- ready_in  in  1  downstream ready
- count  out  $clog2(DEPTH+1)  entries held
- almost_full  out  1  count ≥ AFULL_THRESH

## Operation
- Push when valid_in && ready_out; pop when valid_out && ready_in. Each transfer happens on the rising edge.
- Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally at DEPTH.
- count updates as follows: +1 on push only, −1 on pop only, unchanged on push+pop or idle.
- Register-derived outputs:
  - valid_out = (count != 0)
  - ready_out = (count != DEPTH) && !reset
  - data_out = mem[rd_ptr]
  - almost_full = (count ≥ AFULL_THRESH)
- No combinational path exists from ready_in to ready_out, or from valid_in/data_in to any output.
- Full, with ready_in=1: the pop occurs, but no push is accepted that cycle (ready_out=0). ready_out rises on the next cycle.
- Empty, with valid_in=1: the push occurs, there is no pop, and valid_out rises on the next cycle. There is no bypass.
- Simultaneous push and pop at 0<count<DEPTH: both pointers advance and count holds.
- data_out holds its value while valid_out && !ready_in (AXI-style stability). Upstream may change data_in freely while ready_out=0.
- Reset, including mid-operation: pointers=0, count=0, valid_out=0, almost_full=0, data_out=0, and ready_out=0 while reset is high. All stored entries are discarded. ready_out becomes 1 at the first cycle after release.

## Timing
- Latency: a push accepted at edge N gives valid_out=1 after edge N, so the data is visible in cycle N+1.
- Throughput is 1 transfer per cycle sustained whenever ready_in=1, for any DEPTH ≥2.
- After count reaches DEPTH, ready_out falls in the same cycle the count register updates. A pop at edge M gives ready_out=1 after edge M.
- almost_full and count are valid in the cycle after the edge that changed them.

## Configuration
- Macro SKID_FIFO_STATS_EN.
- When defined:
  - Extra output stall_cycles[31:0] counts cycles with valid_in && !ready_out. It saturates at 2^32−1.
  - Extra output max_count (count width) is a high-water mark of count.
  - Both clear on reset.
- When undefined: neither port nor its logic exists, and the functional behaviour is identical.

## Structure
- Package skid_fifo_pkg holds:
  - STAT_WIDTH = 32
  - function cnt_width(depth) returning $clog2(depth+1)
  - a parameter-check helper that flags a non-power-of-two DEPTH or AFULL_THRESH outside 1..DEPTH
- Sub-module skid_fifo_stats holds the stall counter and watermark. It is instantiated only under SKID_FIFO_STATS_EN.
- The pointer/count/storage logic stays in skid_fifo.

## Test plan
- Reset: hold reset high with valid_in=1. Expect ready_out=0, valid_out=0, count=0. After release, expect ready_out=1 the next cycle.
- Streaming: DEPTH=4, ready_in=1, push 0x01..0x10 back-to-back. Expect 0x01..0x10 out in order, one per cycle, 1-cycle latency, count ≤1.
- Fill and backpressure: ready_in=0, push 0xA0,0xA1,0xA2,0xA3. Expect count=4, ready_out=0, almost_full=1 from count=3. Further 0xA4 is held upstream. Raise ready_in: 0xA0 appears first, and 0xA4 is accepted one cycle after the first pop.
- Wrap: alternate 3 pushes and 2 pops for 20 cycles with random data. Expect the scoreboard to match, pointer wrap without loss, and count to track a reference model.
- Mid-operation reset: with count=3, pulse reset for one cycle. Expect count=0, valid_out=0, and no stale data after the next push.
- Stats (macro defined): 5 cycles of valid_in=1 while full. Expect stall_cycles=5 and max_count=DEPTH.

Source files
------------

// File: rtl/skid_fifo_pkg.sv
// Shared constants and elaboration helpers for the skid_fifo elastic buffer.
package skid_fifo_pkg;

  localparam int unsigned STAT_WIDTH = 32;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // True when DEPTH is a power of two >= 2 and the almost-full threshold lies in 1..DEPTH.
  function automatic bit param_ok(input int unsigned depth, input int unsigned thresh);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/skid_fifo_stats.sv
// Stall-cycle counter and occupancy high-water mark for skid_fifo.
// Compiled only when SKID_FIFO_STATS_EN is defined.
`ifdef SKID_FIFO_STATS_EN
module skid_fifo_stats
  import skid_fifo_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  ready_out,
  input  logic [CNT_W-1:0]      count,
  output logic [STAT_WIDTH-1:0] stall_cycles,
  output logic [CNT_W-1:0]      max_count
);

  // Saturating stall counter plus running maximum of the occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      max_count    <= '0;
    end else begin
      if (valid_in && !ready_out && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STAT_WIDTH'(1);
      if (count > max_count)
        max_count <= count;
    end
  end

endmodule
`endif

// File: rtl/skid_fifo.sv
// DEPTH-entry valid/ready elastic FIFO with registered handshakes, occupancy and almost-full.
// Define SKID_FIFO_STATS_EN to add the stall_cycles / max_count statistics ports.
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ready_out,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ready_in,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         almost_full
`ifdef SKID_FIFO_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]        stall_cycles,
  output logic [cnt_width(DEPTH)-1:0]  max_count
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (!param_ok(DEPTH, AFULL_THRESH)) begin : g_bad_params
    $error("skid_fifo: DEPTH must be a power of two >= 2 and AFULL_THRESH within 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  logic                  valid_q;
  logic                  full_q;
  logic                  afull_q;
  logic                  push;
  logic                  pop;

  // Handshakes see only registered flags, so no input reaches an output combinationally.
  assign push = valid_in && ready_out;
  assign pop  = valid_q && ready_in;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)
      count_nxt = count_q + CNT_W'(1);
    else if (pop && !push)
      count_nxt = count_q - CNT_W'(1);
  end

  // Status flags are precomputed from the next count so they are plain flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      afull_q <= (count_nxt >= CNT_W'(AFULL_THRESH));
    end
  end

  assign ready_out   = !full_q && !reset;
  assign valid_out   = valid_q;
  assign data_out    = mem[rd_ptr];
  assign count       = count_q;
  assign almost_full = afull_q;

`ifdef SKID_FIFO_STATS_EN
  skid_fifo_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .count        (count_q),
    .stall_cycles (stall_cycles),
    .max_count    (max_count)
  );
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Directed self-checking bench for skid_fifo (DEPTH=4, DATA_WIDTH=8, AFULL_THRESH=3).
module tb_skid_fifo;
  import skid_fifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned CW    = cnt_width(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;
  logic [CW-1:0] count;
  logic          almost_full;
`ifdef SKID_FIFO_STATS_EN
  logic [31:0]   stall_cycles;
  logic [CW-1:0] max_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skid_fifo #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_out    (ready_out),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .ready_in     (ready_in),
    .count        (count),
    .almost_full  (almost_full)
`ifdef SKID_FIFO_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .max_count    (max_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; data_in = 8'h5C; ready_in = 1'b0;
    step(); step();
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %0h expected 0", data_out); end
    reset = 1'b0; valid_in = 1'b0;
    step();
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL release_ready_out: got %b expected 1", ready_out); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL release_count: got %0d expected 0", count); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = DW'(i + 1);
      valid_in = 1'b1; data_in = exp;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL stream_ready_out[%0d]: got %b expected 1", i, ready_out); end
      step();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, valid_out); end
      checks++; if (data_out !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, data_out, exp); end
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
    end
    valid_in = 1'b0;
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", valid_out); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL stream_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_fill_backpressure();
    logic [DW-1:0] vals [4];
    logic [DW-1:0] tail;
    vals[0] = 8'hA0; vals[1] = 8'hA1; vals[2] = 8'hA2; vals[3] = 8'hA3;
    ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1; data_in = vals[k];
      step();
      checks++; if (count !== CW'(k + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count, k + 1); end
      checks++; if (almost_full !== (k + 1 >= 3)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", k, almost_full, (k + 1 >= 3)); end
      checks++; if (ready_out !== (k + 1 != 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", k, ready_out, (k + 1 != 4)); end
    end
    data_in = 8'hA4;
    step();
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL held_count: got %0d expected 4", count); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL held_ready: got %b expected 0", ready_out); end
    checks++; if (data_out !== 8'hA0) begin errors++; $display("FAIL held_head: got %0h expected a0", data_out); end
    ready_in = 1'b1;
    step();
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL first_pop_count: got %0d expected 3", count); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL first_pop_ready: got %b expected 1", ready_out); end
    checks++; if (data_out !== 8'hA1) begin errors++; $display("FAIL first_pop_head: got %0h expected a1", data_out); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL first_pop_afull: got %b expected 1", almost_full); end
    step();
    valid_in = 1'b0;
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL a4_accept_count: got %0d expected 3", count); end
    checks++; if (data_out !== 8'hA2) begin errors++; $display("FAIL a4_accept_head: got %0h expected a2", data_out); end
    step();
    step();
    tail = 8'hA4;
    checks++; if (data_out !== tail) begin errors++; $display("FAIL a4_head: got %0h expected %0h", data_out, tail); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL a4_count: got %0d expected 1", count); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fill_drain_valid: got %b expected 0", valid_out); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] q [$];
    logic [DW-1:0] v;
    bit dp;
    bit dq;
    for (int c = 0; c < 20; c++) begin
      valid_in = ((c % 5) < 3);
      ready_in = !valid_in;
      data_in  = DW'($urandom);
      dp = valid_in && (q.size() < int'(DEPTH));
      dq = ready_in && (q.size() > 0);
      checks++; if (ready_out !== (q.size() != int'(DEPTH))) begin errors++; $display("FAIL wrap_ready[%0d]: got %b expected %b", c, ready_out, (q.size() != int'(DEPTH))); end
      if (dq) begin
        v = q.pop_front();
        checks++; if (data_out !== v) begin errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", c, data_out, v); end
      end
      if (dp) q.push_back(data_in);
      step();
      checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", c, count, q.size()); end
      checks++; if (valid_out !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected %b", c, valid_out, (q.size() != 0)); end
    end
    valid_in = 1'b0; ready_in = 1'b1;
    for (int c = 0; c < int'(DEPTH) + 1; c++) begin
      if (q.size() > 0) begin
        v = q.pop_front();
        checks++; if (data_out !== v) begin errors++; $display("FAIL wrap_drain_data[%0d]: got %0h expected %0h", c, data_out, v); end
      end
      step();
      checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL wrap_drain_count[%0d]: got %0d expected %0d", c, count, q.size()); end
    end
  endtask

  task automatic test_mid_reset();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1; data_in = DW'(8'h11 * (k + 1));
      step();
    end
    valid_in = 1'b0;
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
    reset = 1'b1;
    #1;
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", valid_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", ready_out); end
    step();
    reset = 1'b0;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL post_reset_data: got %0h expected 0", data_out); end
    valid_in = 1'b1; data_in = 8'h5A;
    step();
    valid_in = 1'b0;
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL post_reset_head: got %0h expected 5a", data_out); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", count); end
    ready_in = 1'b1;
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL post_reset_stale: got valid %b expected 0", valid_out); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL post_reset_drain: got %0d expected 0", count); end
  endtask

`ifdef SKID_FIFO_STATS_EN
  task automatic test_stats();
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    step();
    reset = 1'b0;
    step();
    valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = DW'(k + 8'h30);
      step();
    end
    for (int k = 0; k < 5; k++) step();
    valid_in = 1'b0;
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_stall: got %0d expected 5", stall_cycles); end
    checks++; if (max_count !== CW'(DEPTH)) begin errors++; $display("FAIL stats_max: got %0d expected %0d", max_count, DEPTH); end
    ready_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL stats_drain: got %0d expected 0", count); end
  endtask
`endif

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    test_reset();
    test_streaming();
    test_fill_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef SKID_FIFO_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
